// File: rtl/scope_pkg.sv
// Shared scope constants: sample width, screen width, capture states
// and trigger slope encodings. Used by the sampler, trigger and VGA blocks.
package scope_pkg;

    localparam int DATA_W     = 12;
    localparam int SCREEN_W   = 640;
    localparam int SCREEN_X_W = 11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PRE_FILL,
        ST_ARMED,
        ST_POST,
        ST_DONE
    } scope_state_e;

    localparam logic SLOPE_RISE = 1'b0;
    localparam logic SLOPE_FALL = 1'b1;

endpackage

// File: rtl/scope_line_ram.sv
// Simple dual-port line RAM: one write port, one registered read port,
// read-before-write on address collision. No reset so it maps to block RAM.
// Ports: clock, wr_en/wr_addr/wr_data (write), rd_addr -> rd_data (1 cycle).
module scope_line_ram #(
    parameter int DATA_W = 12,
    parameter int DEPTH  = 640,
    parameter int ADDR_W = 10
) (
    input  logic              clock,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rd_data_q;

    // Read samples the array before the write lands, so a same-cycle
    // collision returns the old word.
    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        rd_data_q <= mem[rd_addr];
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/scope_trigger_capture.sv
// Trigger-and-capture stage: watches a sample stream for a level crossing,
// captures pre/post-trigger samples into a circular line buffer and freezes
// one screen-width frame for the display side to read by column.
// Ports: clock, reset (async, active-high); sample_valid/sample_data in;
//   trig_level/trig_slope/trig_auto/arm control; screenX -> screenData
//   (1-cycle latency); triggered, frame_ready, busy status.
module scope_trigger_capture #(
    parameter int DATA_W       = scope_pkg::DATA_W,
    parameter int DEPTH        = scope_pkg::SCREEN_W,
    parameter int ADDR_W       = 10,
    parameter int PRE_TRIG     = 64,
    parameter int AUTO_TIMEOUT = 4096
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic                            sample_valid,
    input  logic [DATA_W-1:0]               sample_data,
    input  logic [DATA_W-1:0]               trig_level,
    input  logic                            trig_slope,
    input  logic                            trig_auto,
    input  logic                            arm,
    input  logic [scope_pkg::SCREEN_X_W-1:0] screenX,
    output logic [DATA_W-1:0]               screenData,
    output logic                            triggered,
    output logic                            frame_ready,
    output logic                            busy
);

    import scope_pkg::*;

    localparam int POST_N = DEPTH - PRE_TRIG - 1;
    localparam int TO_W   = $clog2(AUTO_TIMEOUT + 1);
    localparam int SUM_W  = ((ADDR_W > SCREEN_X_W) ? ADDR_W : SCREEN_X_W) + 1;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W-1:0] PRE_LAST  = ADDR_W'(PRE_TRIG - 1);
    localparam logic [ADDR_W-1:0] POST_LAST = ADDR_W'(POST_N - 1);
    localparam logic [TO_W-1:0]   TO_MAX    = TO_W'(AUTO_TIMEOUT);

    function automatic logic [ADDR_W-1:0] ptr_inc(
        input logic [ADDR_W-1:0] p
    );
        return (p == LAST_ADDR) ? '0 : p + ADDR_W'(1);
    endfunction

    // (p - PRE_TRIG) mod DEPTH, kept non-negative by adding DEPTH first.
    function automatic logic [ADDR_W-1:0] ptr_back(
        input logic [ADDR_W-1:0] p
    );
        logic [ADDR_W:0] w;
        w = {1'b0, p} + (ADDR_W+1)'(DEPTH - PRE_TRIG);
        if (w >= (ADDR_W+1)'(DEPTH)) begin
            w = w - (ADDR_W+1)'(DEPTH);
        end
        return ADDR_W'(w);
    endfunction

    scope_state_e      state_q, state_d;
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] pre_cnt_q, pre_cnt_d;
    logic [ADDR_W-1:0] post_cnt_q, post_cnt_d;
    logic [TO_W-1:0]   timeout_q, timeout_d;
    logic [DATA_W-1:0] prev_q, prev_d;
    logic              prev_valid_q, prev_valid_d;
    logic [ADDR_W-1:0] trig_ptr_q, trig_ptr_d;
    logic [ADDR_W-1:0] start_ptr_q, start_ptr_d;
    logic              triggered_q, triggered_d;
    logic              frame_ready_q, frame_ready_d;
    logic              busy_q, busy_d;
    logic              rd_zero_q, rd_zero_d;

    logic              capturing;
    logic              wr_en;
    logic              hit_rise;
    logic              hit_fall;
    logic              hit_level;
    logic              hit_auto;
    logic [TO_W-1:0]   timeout_inc;
    logic [SUM_W-1:0]  rd_sum;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] ram_rd;

    always_comb begin
        hit_rise = prev_valid_q
                && (prev_q < trig_level)
                && (sample_data >= trig_level);
        hit_fall = prev_valid_q
                && (prev_q > trig_level)
                && (sample_data <= trig_level);
        hit_level = 1'b0;
        unique case (trig_slope)
            SLOPE_RISE: hit_level = hit_rise;
            SLOPE_FALL: hit_level = hit_fall;
            default:    hit_level = 1'b0;
        endcase
        // Saturate so normal mode can sit in ARMED indefinitely.
        timeout_inc = (timeout_q == TO_MAX) ? timeout_q
                                            : timeout_q + TO_W'(1);
        hit_auto = trig_auto && (timeout_inc == TO_MAX);
    end

    always_comb begin
        state_d      = state_q;
        wr_ptr_d     = wr_ptr_q;
        pre_cnt_d    = pre_cnt_q;
        post_cnt_d   = post_cnt_q;
        timeout_d    = timeout_q;
        prev_d       = prev_q;
        prev_valid_d = prev_valid_q;
        trig_ptr_d   = trig_ptr_q;
        start_ptr_d  = start_ptr_q;
        triggered_d  = triggered_q;
        wr_en        = 1'b0;

        capturing = (state_q == ST_PRE_FILL)
                 || (state_q == ST_ARMED)
                 || (state_q == ST_POST);

        if (arm) begin
            // Restart from any state; a sample arriving with arm is dropped
            // so every capture starts from a clean, empty history.
            state_d      = ST_PRE_FILL;
            wr_ptr_d     = '0;
            pre_cnt_d    = '0;
            post_cnt_d   = '0;
            timeout_d    = '0;
            prev_valid_d = 1'b0;
            triggered_d  = 1'b0;
        end else begin
            if (capturing && sample_valid) begin
                wr_en        = 1'b1;
                wr_ptr_d     = ptr_inc(wr_ptr_q);
                prev_d       = sample_data;
                prev_valid_d = 1'b1;
            end

            unique case (state_q)
                ST_PRE_FILL: begin
                    if (sample_valid) begin
                        pre_cnt_d = pre_cnt_q + ADDR_W'(1);
                        if (pre_cnt_q == PRE_LAST) begin
                            state_d = ST_ARMED;
                        end
                    end
                end
                ST_ARMED: begin
                    if (sample_valid) begin
                        timeout_d = timeout_inc;
                        if (hit_level || hit_auto) begin
                            trig_ptr_d  = wr_ptr_q;
                            triggered_d = 1'b1;
                            if (POST_N == 0) begin
                                state_d     = ST_DONE;
                                start_ptr_d = ptr_back(wr_ptr_q);
                            end else begin
                                state_d = ST_POST;
                            end
                        end
                    end
                end
                ST_POST: begin
                    if (sample_valid) begin
                        post_cnt_d = post_cnt_q + ADDR_W'(1);
                        if (post_cnt_q == POST_LAST) begin
                            state_d     = ST_DONE;
                            start_ptr_d = ptr_back(trig_ptr_q);
                        end
                    end
                end
                ST_IDLE, ST_DONE: begin
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end

        frame_ready_d = (state_d == ST_DONE);
        busy_d = (state_d == ST_PRE_FILL)
              || (state_d == ST_ARMED)
              || (state_d == ST_POST);
    end

    // Column read: start_ptr + screenX folded once into the buffer range;
    // off-screen columns read as zero via a registered mask.
    always_comb begin
        rd_zero_d = (SUM_W'(screenX) >= SUM_W'(DEPTH));
        rd_sum = SUM_W'(start_ptr_q) + SUM_W'(screenX);
        if (rd_sum >= SUM_W'(DEPTH)) begin
            rd_sum = rd_sum - SUM_W'(DEPTH);
        end
        rd_addr = rd_zero_d ? start_ptr_q : ADDR_W'(rd_sum);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            wr_ptr_q      <= '0;
            pre_cnt_q     <= '0;
            post_cnt_q    <= '0;
            timeout_q     <= '0;
            prev_q        <= '0;
            prev_valid_q  <= 1'b0;
            trig_ptr_q    <= '0;
            start_ptr_q   <= '0;
            triggered_q   <= 1'b0;
            frame_ready_q <= 1'b0;
            busy_q        <= 1'b0;
            rd_zero_q     <= 1'b1;
        end else begin
            state_q       <= state_d;
            wr_ptr_q      <= wr_ptr_d;
            pre_cnt_q     <= pre_cnt_d;
            post_cnt_q    <= post_cnt_d;
            timeout_q     <= timeout_d;
            prev_q        <= prev_d;
            prev_valid_q  <= prev_valid_d;
            trig_ptr_q    <= trig_ptr_d;
            start_ptr_q   <= start_ptr_d;
            triggered_q   <= triggered_d;
            frame_ready_q <= frame_ready_d;
            busy_q        <= busy_d;
            rd_zero_q     <= rd_zero_d;
        end
    end

    scope_line_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clock   (clock),
        .wr_en   (wr_en),
        .wr_addr (wr_ptr_q),
        .wr_data (sample_data),
        .rd_addr (rd_addr),
        .rd_data (ram_rd)
    );

    // The RAM output register has no reset; the mask flop resets high
    // so screenData reads zero straight out of reset.
    assign screenData  = rd_zero_q ? '0 : ram_rd;
    assign triggered   = triggered_q;
    assign frame_ready = frame_ready_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_scope_trigger_capture.sv
// Scoreboard bench for scope_trigger_capture: directed sample streams,
// expected frame values queued at issue time and checked by a monitor.
module tb_scope_trigger_capture;

    typedef struct packed {
        logic        sel;
        logic [11:0] exp;
        logic [15:0] tag;
    } exp_t;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        sample_valid = 1'b0;
    logic [11:0] sample_data = '0;
    logic [11:0] trig_level = 12'd2048;
    logic        trig_slope = 1'b0;
    logic        trig_auto = 1'b0;
    logic        arm = 1'b0;
    logic [10:0] screenX = 11'd700;
    logic [11:0] screenData;
    logic        triggered;
    logic        frame_ready;
    logic        busy;

    int   n_tests = 0;
    int   n_fail = 0;
    exp_t sbq[$];
    logic chk_strobe = 1'b0;
    exp_t mon_e;
    logic [11:0] mon_act;

    always #10 clock = ~clock;

    scope_trigger_capture dut (
        .clock        (clock),
        .reset        (reset),
        .sample_valid (sample_valid),
        .sample_data  (sample_data),
        .trig_level   (trig_level),
        .trig_slope   (trig_slope),
        .trig_auto    (trig_auto),
        .arm          (arm),
        .screenX      (screenX),
        .screenData   (screenData),
        .triggered    (triggered),
        .frame_ready  (frame_ready),
        .busy         (busy)
    );

    // Sample value of stream t at index i (index 0 = first sample after arm).
    function automatic logic [11:0] sample_of(input int t, input int i);
        case (t)
            1: return (i < 512) ? 12'(8 * i) : 12'd4088;
            3: return 12'd100;
            4: begin
                if (i < 64) return (i % 2 == 1) ? 12'(3000 + i) : 12'(i);
                if (i < 70) return 12'(500 + i);
                return 12'(2100 + i);
            end
            6: begin
                if (i < 660) return 12'(i);
                if (i == 660) return 12'd3000;
                return 12'(2000 + i);
            end
            default: return 12'd0;
        endcase
    endfunction

    // Column k of a frame whose trigger was sample ti (64 pre-trigger).
    function automatic logic [11:0] frame_exp(input int t, input int ti,
                                              input int k);
        if (k >= 640) return 12'd0;
        return sample_of(t, ti - 64 + k);
    endfunction

    always @(posedge clock) begin
        if (chk_strobe) begin
            @(negedge clock);
            if (sbq.size() == 0) begin
                n_fail++;
                $display("FAIL scoreboard_underflow actual=empty required=entry");
            end else begin
                mon_e = sbq.pop_front();
                n_tests++;
                mon_act = mon_e.sel ? {9'd0, triggered, frame_ready, busy}
                                    : screenData;
                if (mon_act !== mon_e.exp) begin
                    n_fail++;
                    $display("FAIL %s tag=%0d actual=%0d required=%0d",
                             mon_e.sel ? "status" : "screen",
                             mon_e.tag, mon_act, mon_e.exp);
                end
            end
        end
    end

    task automatic send(input logic [11:0] v);
        sample_data  = v;
        sample_valid = 1'b1;
        @(posedge clock);
        #1;
        sample_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic pulse_arm();
        arm = 1'b1;
        @(posedge clock);
        #1;
        arm = 1'b0;
    endtask

    task automatic stream(input int t, input int from, input int to,
                          input bit gaps);
        for (int i = from; i < to; i++) begin
            send(sample_of(t, i));
            if (gaps && (i % 3 == 2)) idle(1);
        end
    endtask

    task automatic expect_q(input logic sel, input logic [11:0] e,
                            input int tag, input logic [10:0] x);
        exp_t en;
        screenX = x;
        en.sel = sel;
        en.exp = e;
        en.tag = 16'(tag);
        sbq.push_back(en);
        chk_strobe = 1'b1;
        @(posedge clock);
        #1;
        chk_strobe = 1'b0;
    endtask

    task automatic rd(input int x, input logic [11:0] e, input int tag);
        expect_q(1'b0, e, tag, 11'(x));
    endtask

    // Status word is {triggered, frame_ready, busy}.
    task automatic stat(input logic [2:0] e, input int tag);
        expect_q(1'b1, {9'd0, e}, tag, screenX);
    endtask

    task automatic direct(input int tag, input logic [11:0] act,
                          input logic [11:0] e);
        n_tests++;
        if (act !== e) begin
            n_fail++;
            $display("FAIL direct tag=%0d actual=%0d required=%0d",
                     tag, act, e);
        end
    endtask

    initial begin
        // Reset values
        #1 reset = 1'b1;
        #1;
        direct(1, screenData, 12'd0);
        direct(2, {9'd0, triggered, frame_ready, busy}, 12'd0);
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;
        stat(3'b000, 3);
        rd(700, 12'd0, 4);

        // Rising ramp, normal mode, sparse valid strobes
        trig_slope = 1'b0;
        pulse_arm();
        stream(1, 0, 257, 1'b1);
        stat(3'b101, 100);
        stream(1, 257, 832, 1'b1);
        stat(3'b110, 101);
        rd(64, 12'd2048, 102);
        rd(0, 12'd1536, 103);
        rd(1, frame_exp(1, 256, 1), 104);
        rd(319, frame_exp(1, 256, 319), 105);
        rd(447, frame_exp(1, 256, 447), 106);
        rd(448, frame_exp(1, 256, 448), 107);
        rd(639, frame_exp(1, 256, 639), 108);
        rd(640, 12'd0, 109);

        // Same ramp on falling slope: never triggers
        trig_slope = 1'b1;
        pulse_arm();
        stream(1, 0, 10000, 1'b0);
        stat(3'b001, 200);

        // Auto mode forces a trigger on the 4096th ARMED sample
        trig_slope = 1'b0;
        trig_auto = 1'b1;
        pulse_arm();
        stream(3, 0, 4159, 1'b0);
        stat(3'b001, 300);
        stream(3, 4159, 4160, 1'b0);
        stat(3'b101, 301);
        stream(3, 4160, 4735, 1'b0);
        stat(3'b110, 302);
        for (int k = 0; k < 640; k++) rd(k, 12'd100, 310);
        rd(640, 12'd0, 311);
        trig_auto = 1'b0;

        // Crossings during pre-fill are ignored
        pulse_arm();
        stream(4, 0, 64, 1'b0);
        stat(3'b001, 400);
        stream(4, 64, 646, 1'b0);
        stat(3'b110, 401);
        rd(64, 12'd2170, 402);
        rd(0, 12'd6, 403);
        rd(57, 12'd3063, 404);
        rd(58, 12'd564, 405);
        rd(639, 12'd2745, 406);

        // Reset in the middle of POST
        pulse_arm();
        stream(1, 0, 300, 1'b0);
        stat(3'b101, 500);
        @(negedge clock);
        reset = 1'b1;
        #1;
        direct(501, {11'd0, triggered}, 12'd0);
        direct(502, {11'd0, frame_ready}, 12'd0);
        direct(503, {11'd0, busy}, 12'd0);
        direct(504, screenData, 12'd0);
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
        stat(3'b000, 505);
        pulse_arm();
        stream(1, 0, 832, 1'b0);
        stat(3'b110, 506);
        rd(64, 12'd2048, 507);
        rd(0, 12'd1536, 508);
        rd(500, frame_exp(1, 256, 500), 509);

        // Trigger at buffer address 20 after wr_ptr wrap
        pulse_arm();
        stream(6, 0, 661, 1'b0);
        stat(3'b101, 600);
        stream(6, 661, 1236, 1'b0);
        stat(3'b110, 601);
        rd(0, 12'd596, 602);
        rd(64, 12'd3000, 603);
        rd(43, 12'd639, 604);
        rd(44, 12'd640, 605);
        rd(639, 12'd3235, 606);
        rd(640, 12'd0, 607);
        rd(700, 12'd0, 608);
        rd(2047, 12'd0, 609);

        repeat (4) @(posedge clock);
        #1;
        if (sbq.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain actual=%0d required=0",
                     sbq.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
